way_burst_reader: RTL and testbench
===================================

# way_burst_reader

Way data read engine between the cache controller and the way data arrays. Accepts a hit read request (one-hot way select, word offset, single/burst mode), drives the shared word offset to all ways, selects the hit way's data with an AND-OR mux, and returns words on a valid/ready response channel. Burst mode returns the full line critical-word-first with wrap-around. A 2-entry output buffer absorbs backpressure. Way arrays have a 1-cycle synchronous read.

## Interface
- NUM_WAYS, 8, number of ways (≥1)
- DATA_WIDTH, 32, word width
- WORDS_PER_LINE, 8, words per line (power of 2, ≥2)
- OFFSET_WIDTH, $clog2(WORDS_PER_LINE), derived; not overridden
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- reqValid  in  1  request valid
- reqReady  out  1  request ready; transfer when reqValid && reqReady
- reqWay  in  NUM_WAYS  one-hot hit way
- reqOffset  in  OFFSET_WIDTH  critical word offset
- reqBurst  in  1  1 = full line, 0 = single word
- wayRdEn  out  1  read strobe to all ways
- wayOffset  out  OFFSET_WIDTH  word offset broadcast to all ways
- wayData  in  NUM_WAYS*DATA_WIDTH  way i data in bits [i*DATA_WIDTH +: DATA_WIDTH], valid the cycle after wayRdEn
- rspValid  out  1  response beat valid
- rspReady  in  1  response accepted
- rspData  out  DATA_WIDTH  word
- rspLast  out  1  final beat of request
- rspError  out  1  reqWay was not one-hot

## Operation
- States: IDLE, ISSUE.
- IDLE: reqReady=1. On accept, latch reqWay, reqOffset, beat count (WORDS_PER_LINE if reqBurst, else 1) and error flag (reqWay zero or multi-hot); go to ISSUE.
- ISSUE, valid request: in each cycle with a free credit, assert wayRdEn with wayOffset = current offset, then offset = offset+1 mod WORDS_PER_LINE and decrement count. After the last issue, return to IDLE.
- ISSUE, error request: no wayRdEn. Push one beat directly: rspData=0, rspError=1, rspLast=1. Return to IDLE.
- Returned data: the cycle after each wayRdEn, rspData candidate = OR over i of (latched way bit i ? wayData slice i : 0). It is pushed into the buffer with rspLast set on the final issued beat and rspError=0.
- Credits: issue only if (buffer occupancy + reads in flight − pop this cycle) < 2. This allows 1 beat/cycle with rspReady held high. The buffer can never overflow.
- Buffer: 2-entry FIFO. Its head drives rspValid/rspData/rspLast/rspError. Pop when rspValid && rspReady.
- A new request may be accepted once the state is IDLE, even while prior beats are still buffered. Responses are returned strictly in order.
- wayOffset holds its last value when wayRdEn=0.

## Timing
- Reset (asynchronous, immediate): reqReady=0, wayRdEn=0, wayOffset=0, rspValid=0, rspData=0, rspLast=0, rspError=0. FIFO, in-flight tracking and state are cleared to IDLE. reqReady rises at the first clk edge after rst_n deasserts.
- Accept at edge t → first wayRdEn in cycle t+1 → data captured at edge t+2 → rspValid high in cycle t+2 onward, after that edge (3-cycle request-to-first-beat latency).
- Burst with rspReady=1: WORDS_PER_LINE consecutive beats, no bubbles.
- rspData/rspLast/rspError are stable while rspValid && !rspReady.
- Push and pop in the same cycle on a full buffer are legal: occupancy is unchanged.
- Reset mid-burst: all in-flight and buffered beats are discarded, and way data arriving after reset is ignored.
- reqReady=0 for the whole of ISSUE. A request held in that state stays pending.

## Test plan
- Single read: reqWay=8'b0000_0100, reqOffset=5, reqBurst=0, wayData word = 0x200+offset → one beat 0x205, rspLast=1, rspError=0, rspValid 3 cycles after accept.
- Burst wrap: reqWay=way 7, reqOffset=6, rspReady=1 → wayOffset sequence 6,7,0,1,2,3,4,5 on consecutive cycles. 8 back-to-back beats in that order, rspLast only on the 8th.
- Backpressure: rspReady=0 for 5 cycles starting at beat 2 of a burst → at most 2 beats outstanding, wayRdEn stalls, rspData stable. After release, all 8 beats arrive in order with none lost or duplicated.
- Bad select: reqWay=0, then reqWay=8'b0001_1000 → each produces one beat with data 0, rspError=1, rspLast=1, and wayRdEn is never asserted.
- Reset mid-burst: assert rst_n low after beat 3 → all outputs 0 immediately. reqReady=1 one edge after release, and a new single read returns correct data.
- Back-to-back: a burst followed by a single read accepted as soon as IDLE → 9 beats in order, with two rspLast pulses (beats 8 and 9).

Source files
------------

// File: rtl/way_burst_reader.sv
// way_burst_reader
//   Reads hit-way data for the cache controller. Accepts one request at a time:
//   a one-hot way select, a critical word offset and a single/burst mode. The word
//   offset goes to every way array. The arrays have a 1-cycle synchronous read. The
//   hit way's word is chosen with an AND-OR mux. Words return on a valid/ready
//   channel through a 2-entry buffer. A burst returns the whole line, critical
//   word first, and wraps around the end of the line.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   reqValid/reqReady   request handshake
//   reqWay              one-hot hit way; zero or multi-hot returns an error beat
//   reqOffset           critical word offset
//   reqBurst            1 = full line, 0 = single word
//   wayRdEn, wayOffset  read strobe and word offset sent to all ways
//   wayData             concatenated way read data, valid the cycle after wayRdEn
//   rspValid/rspReady   response handshake
//   rspData, rspLast    response word and final-beat marker
//   rspError            the request's way select was not one-hot
module way_burst_reader #(
   parameter int NUM_WAYS       = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int WORDS_PER_LINE = 8,
   parameter int OFFSET_WIDTH   = $clog2(WORDS_PER_LINE)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           reqValid,
   output logic                           reqReady,
   input  logic [NUM_WAYS-1:0]            reqWay,
   input  logic [OFFSET_WIDTH-1:0]        reqOffset,
   input  logic                           reqBurst,
   output logic                           wayRdEn,
   output logic [OFFSET_WIDTH-1:0]        wayOffset,
   input  logic [NUM_WAYS*DATA_WIDTH-1:0] wayData,
   output logic                           rspValid,
   input  logic                           rspReady,
   output logic [DATA_WIDTH-1:0]          rspData,
   output logic                           rspLast,
   output logic                           rspError
);

   localparam int CNT_W = $clog2(WORDS_PER_LINE + 1);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                  state_q, state_d;
   logic                    started_q;
   logic [NUM_WAYS-1:0]     way_q;
   logic [OFFSET_WIDTH-1:0] off_q, last_off_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    err_q;
   logic                    rd_pend_q, rd_last_q;

   logic [DATA_WIDTH-1:0]   f_data [2];
   logic                    f_last [2];
   logic                    f_err  [2];
   logic                    rptr_q, wptr_q;
   logic [1:0]              occ_q;

   logic                    accept, pop, credit, issue, err_push, push;
   logic                    req_bad;
   logic [DATA_WIDTH-1:0]   sel_data;

   // started_q keeps reqReady low until the first edge after reset is released.
   assign reqReady = started_q && (state_q == IDLE);
   assign accept   = reqValid && reqReady;
   assign rspValid = (occ_q != 2'd0);
   assign pop      = rspValid && rspReady;
   assign req_bad  = (reqWay == '0) || ((reqWay & (reqWay - 1'b1)) != '0);

   // occupancy + in flight - pop < 2, written without the subtraction.
   assign credit   = ({1'b0, occ_q} + {2'b00, rd_pend_q}) < (3'd2 + {2'b00, pop});
   assign issue    = (state_q == ISSUE) && !err_q && credit;
   assign err_push = (state_q == ISSUE) && err_q && credit;
   assign push     = rd_pend_q || err_push;

   assign wayRdEn   = issue;
   assign wayOffset = issue ? off_q : last_off_q;

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_WAYS; i++) begin
         sel_data = sel_data | (wayData[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{way_q[i]}});
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE:   if (err_push || (issue && cnt_q == CNT_W'(1))) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         started_q  <= 1'b0;
         way_q      <= '0;
         off_q      <= '0;
         last_off_q <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         started_q <= 1'b1;
         rd_pend_q <= issue;
         rd_last_q <= issue && (cnt_q == CNT_W'(1));
         if (accept) begin
            way_q <= reqWay;
            off_q <= reqOffset;
            cnt_q <= reqBurst ? CNT_W'(WORDS_PER_LINE) : CNT_W'(1);
            err_q <= req_bad;
         end else if (issue) begin
            off_q      <= off_q + 1'b1;
            last_off_q <= off_q;
            cnt_q      <= cnt_q - 1'b1;
         end
      end
   end

   // A push and a pop on a full buffer write the slot being popped. Credits
   // prevent a push to a full buffer in any other case.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) begin
            f_data[i] <= '0;
            f_last[i] <= 1'b0;
            f_err[i]  <= 1'b0;
         end
         rptr_q <= 1'b0;
         wptr_q <= 1'b0;
         occ_q  <= 2'd0;
      end else begin
         if (push) begin
            f_data[wptr_q] <= rd_pend_q ? sel_data : '0;
            f_last[wptr_q] <= rd_pend_q ? rd_last_q : 1'b1;
            f_err[wptr_q]  <= !rd_pend_q;
            wptr_q         <= !wptr_q;
         end
         if (pop) rptr_q <= !rptr_q;
         occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
      end
   end

   assign rspData  = f_data[rptr_q];
   assign rspLast  = f_last[rptr_q];
   assign rspError = f_err[rptr_q];

endmodule

// File: tb/tb_way_burst_reader.sv
// tb_way_burst_reader
//   Testbench for way_burst_reader. The way arrays are modelled with a 1-cycle
//   synchronous read. Expected beats come from a line-level model: the words of
//   the line in wrap order, read from the hit way's index.
module tb_way_burst_reader;
   localparam int NW  = 8;
   localparam int DW  = 32;
   localparam int WPL = 8;
   localparam int OW  = $clog2(WPL);

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
      logic          e;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             reqValid = 1'b0;
   logic             reqReady;
   logic [NW-1:0]    reqWay = '0;
   logic [OW-1:0]    reqOffset = '0;
   logic             reqBurst = 1'b0;
   logic             wayRdEn;
   logic [OW-1:0]    wayOffset;
   logic [NW*DW-1:0] wayData = '0;
   logic             rspValid;
   logic             rspReady = 1'b0;
   logic [DW-1:0]    rspData;
   logic             rspLast;
   logic             rspError;

   int               checks = 0;
   int               errors = 0;
   logic [DW-1:0]    base = '0;
   beat_t            obs[$];
   beat_t            exp[$];
   int               offs[$];

   always #5 clk = ~clk;

   way_burst_reader #(.NUM_WAYS(NW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL)) dut (
      .clk(clk), .rst_n(rst_n),
      .reqValid(reqValid), .reqReady(reqReady), .reqWay(reqWay),
      .reqOffset(reqOffset), .reqBurst(reqBurst),
      .wayRdEn(wayRdEn), .wayOffset(wayOffset), .wayData(wayData),
      .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
      .rspLast(rspLast), .rspError(rspError)
   );

   function automatic logic [DW-1:0] word(input int way, input int off);
      return base + DW'(way * 256) + DW'(off);
   endfunction

   always @(posedge clk) begin
      if (wayRdEn) begin
         for (int i = 0; i < NW; i++) wayData[i*DW +: DW] <= word(i, int'(wayOffset));
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (rspValid && rspReady) obs.push_back('{rspData, rspLast, rspError});
         if (wayRdEn) offs.push_back(int'(wayOffset));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   function automatic void model(input logic [NW-1:0] way, input int off, input bit burst);
      int n = burst ? WPL : 1;
      int idx = 0;
      if ($countones(way) != 1) begin
         exp.push_back('{'0, 1'b1, 1'b1});
         return;
      end
      for (int i = 0; i < NW; i++) if (way[i]) idx = i;
      for (int k = 0; k < n; k++) exp.push_back('{word(idx, (off + k) % WPL), k == n - 1, 1'b0});
   endfunction

   task automatic clear_queues();
      obs.delete();
      exp.delete();
      offs.delete();
   endtask

   task automatic send(input logic [NW-1:0] way, input int off, input bit burst);
      int t = 0;
      reqWay = way; reqOffset = OW'(off); reqBurst = burst; reqValid = 1'b1;
      while (!reqReady && t < 100) begin @(negedge clk); t++; end
      checks++;
      if (!reqReady) begin errors++; $display("FAIL accept: got reqReady=0, expected 1 within 100 cycles"); end
      @(negedge clk);
      reqValid = 1'b0;
      model(way, off, burst);
   endtask

   task automatic wait_beats(input int n);
      int t = 0;
      while (obs.size() < n && t < 300) begin @(negedge clk); t++; end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({reqReady, wayRdEn, wayOffset, rspValid, rspData, rspLast, rspError} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b en=%b off=%0d v=%b d=%h l=%b e=%b, expected all 0",
                  reqReady, wayRdEn, wayOffset, rspValid, rspData, rspLast, rspError);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (reqReady !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b, expected 0", reqReady); end
      @(posedge clk); #1;
      checks++;
      if (reqReady !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b, expected 1", reqReady); end
      @(negedge clk);
   endtask

   task automatic test_single();
      clear_queues();
      base = '0;
      rspReady = 1'b1;
      send(8'b0000_0100, 5, 1'b0);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rspValid !== (k == 2)) begin
            errors++; $display("FAIL single_latency k=%0d: got rspValid=%b, expected %b", k, rspValid, k == 2);
         end
         @(negedge clk);
      end
      wait_beats(1);
      checks++;
      if (obs.size() != 1) begin errors++; $display("FAIL single_count: got %0d, expected 1", obs.size()); end
      checks++;
      if (obs.size() > 0 && obs[0] !== beat_t'{32'h205, 1'b1, 1'b0}) begin
         errors++; $display("FAIL single_beat: got d=%h l=%b e=%b, expected d=205 l=1 e=0", obs[0].d, obs[0].l, obs[0].e);
      end
   endtask

   task automatic test_burst_wrap();
      clear_queues();
      base = $urandom;
      rspReady = 1'b1;
      send(8'b1000_0000, 6, 1'b1);
      for (int k = 0; k < 10; k++) begin
         if (k < 8) begin
            checks++;
            if (wayRdEn !== 1'b1 || int'(wayOffset) != (6 + k) % WPL) begin
               errors++; $display("FAIL wrap_issue k=%0d: got en=%b off=%0d, expected en=1 off=%0d", k, wayRdEn, wayOffset, (6 + k) % WPL);
            end
         end
         if (k >= 2) begin
            checks++;
            if (rspValid !== 1'b1) begin errors++; $display("FAIL wrap_no_bubble k=%0d: got rspValid=%b, expected 1", k, rspValid); end
         end
         @(negedge clk);
      end
      wait_beats(8);
      checks++;
      if (obs.size() != 8) begin errors++; $display("FAIL wrap_count: got %0d, expected 8", obs.size()); end
      for (int k = 0; k < obs.size() && k < exp.size(); k++) begin
         checks++;
         if (obs[k] !== exp[k]) begin
            errors++; $display("FAIL wrap_beat %0d: got d=%h l=%b e=%b, expected d=%h l=%b e=%b",
                               k, obs[k].d, obs[k].l, obs[k].e, exp[k].d, exp[k].l, exp[k].e);
         end
      end
   endtask

   task automatic test_backpressure();
      int t = 0;
      logic [NW-1:0] way;
      clear_queues();
      base = $urandom;
      way = NW'(1) << $urandom_range(NW - 1);
      rspReady = 1'b1;
      send(way, int'($urandom_range(WPL - 1)), 1'b1);
      while (obs.size() < 1 && t < 50) begin @(negedge clk); t++; end
      rspReady = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (offs.size() - obs.size() > 2) begin
            errors++; $display("FAIL bp_outstanding k=%0d: got %0d, expected <=2", k, offs.size() - obs.size());
         end
         if (k >= 2) begin
            checks++;
            if (wayRdEn !== 1'b0) begin errors++; $display("FAIL bp_stall k=%0d: got wayRdEn=%b, expected 0", k, wayRdEn); end
            checks++;
            if (rspValid !== 1'b1 || obs.size() >= exp.size() || rspData !== exp[obs.size()].d) begin
               errors++; $display("FAIL bp_stable k=%0d: got v=%b d=%h, expected v=1 d=%h",
                                  k, rspValid, rspData, exp[obs.size() % WPL].d);
            end
         end
      end
      rspReady = 1'b1;
      wait_beats(8);
      checks++;
      if (obs.size() != 8) begin errors++; $display("FAIL bp_count: got %0d, expected 8", obs.size()); end
      for (int k = 0; k < obs.size() && k < exp.size(); k++) begin
         checks++;
         if (obs[k] !== exp[k]) begin
            errors++; $display("FAIL bp_beat %0d: got d=%h l=%b, expected d=%h l=%b", k, obs[k].d, obs[k].l, exp[k].d, exp[k].l);
         end
      end
   endtask

   task automatic test_bad_select();
      clear_queues();
      rspReady = 1'b1;
      send(8'b0000_0000, int'($urandom_range(WPL - 1)), 1'b1);
      send(8'b0001_1000, int'($urandom_range(WPL - 1)), 1'b0);
      wait_beats(2);
      checks++;
      if (obs.size() != 2) begin errors++; $display("FAIL bad_count: got %0d, expected 2", obs.size()); end
      checks++;
      if (offs.size() != 0) begin errors++; $display("FAIL bad_no_read: got %0d reads, expected 0", offs.size()); end
      for (int k = 0; k < obs.size() && k < exp.size(); k++) begin
         checks++;
         if (obs[k] !== exp[k]) begin
            errors++; $display("FAIL bad_beat %0d: got d=%h l=%b e=%b, expected d=%h l=%b e=%b",
                               k, obs[k].d, obs[k].l, obs[k].e, exp[k].d, exp[k].l, exp[k].e);
         end
      end
   endtask

   task automatic test_reset_mid();
      int t = 0;
      clear_queues();
      base = $urandom;
      rspReady = 1'b1;
      send(NW'(1) << $urandom_range(NW - 1), int'($urandom_range(WPL - 1)), 1'b1);
      while (obs.size() < 3 && t < 50) begin @(negedge clk); t++; end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({reqReady, wayRdEn, wayOffset, rspValid, rspData, rspLast, rspError} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got rdy=%b en=%b off=%0d v=%b d=%h l=%b e=%b, expected all 0",
                  reqReady, wayRdEn, wayOffset, rspValid, rspData, rspLast, rspError);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (reqReady !== 1'b0) begin errors++; $display("FAIL midreset_ready_low: got %b, expected 0", reqReady); end
      @(posedge clk); #1;
      checks++;
      if (reqReady !== 1'b1) begin errors++; $display("FAIL midreset_ready_rise: got %b, expected 1", reqReady); end
      @(negedge clk);
      clear_queues();
      base = $urandom;
      send(NW'(1) << $urandom_range(NW - 1), int'($urandom_range(WPL - 1)), 1'b0);
      wait_beats(1);
      checks++;
      if (obs.size() != 1) begin errors++; $display("FAIL midreset_count: got %0d, expected 1", obs.size()); end
      checks++;
      if (obs.size() > 0 && obs[0] !== exp[0]) begin
         errors++; $display("FAIL midreset_beat: got d=%h l=%b e=%b, expected d=%h l=%b e=%b",
                            obs[0].d, obs[0].l, obs[0].e, exp[0].d, exp[0].l, exp[0].e);
      end
   endtask

   task automatic test_back_to_back();
      int lasts = 0;
      clear_queues();
      base = $urandom;
      rspReady = 1'b1;
      send(NW'(1) << $urandom_range(NW - 1), int'($urandom_range(WPL - 1)), 1'b1);
      send(NW'(1) << $urandom_range(NW - 1), int'($urandom_range(WPL - 1)), 1'b0);
      wait_beats(9);
      checks++;
      if (obs.size() != 9) begin errors++; $display("FAIL b2b_count: got %0d, expected 9", obs.size()); end
      for (int k = 0; k < obs.size() && k < exp.size(); k++) begin
         if (obs[k].l) lasts++;
         checks++;
         if (obs[k] !== exp[k]) begin
            errors++; $display("FAIL b2b_beat %0d: got d=%h l=%b e=%b, expected d=%h l=%b e=%b",
                               k, obs[k].d, obs[k].l, obs[k].e, exp[k].d, exp[k].l, exp[k].e);
         end
      end
      checks++;
      if (lasts != 2) begin errors++; $display("FAIL b2b_lasts: got %0d, expected 2", lasts); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst_wrap();
      test_backpressure();
      test_bad_select();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
